// File: rtl/activation_pipe_multi_if.sv
// Sample/result handshake plus LUT write port for activation_pipe_multi.
// master = sample producer / result consumer, slave = the pipeline.
interface activation_pipe_multi_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int LUT_ADDR_WIDTH = 6
);
  logic                      in_valid;
  logic                      in_ready;
  logic [1:0]                in_mode;
  logic [DATA_WIDTH-1:0]     in_data;
  logic                      lut_wr_en;
  logic [LUT_ADDR_WIDTH-1:0] lut_wr_addr;
  logic [DATA_WIDTH-1:0]     lut_data;
  logic                      idle;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_WIDTH-1:0]     out_data;

  modport master (
    output in_valid, in_mode, in_data, lut_wr_en, lut_wr_addr, lut_data, out_ready,
    input  in_ready, idle, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_mode, in_data, lut_wr_en, lut_wr_addr, lut_data, out_ready,
    output in_ready, idle, out_valid, out_data
  );
endinterface

// File: rtl/activation_pipe_multi.sv
// Fixed-point activation pipeline: bypass, ReLU, leaky ReLU or interpolated LUT.
// Whole pipe stalls in place on output backpressure; LUT writable only while empty.
module activation_pipe_multi #(
  parameter int DATA_WIDTH     = 16,
  parameter int FRAC_BITS      = 8,
  parameter int LUT_ADDR_WIDTH = 6,
  parameter int LEAK_SHIFT     = 3
) (
  input logic                    clk,
  input logic                    rst,
  activation_pipe_multi_if.slave bus
);
  localparam int DEPTH = 2 ** LUT_ADDR_WIDTH;
  localparam int PW    = DATA_WIDTH + FRAC_BITS + 2;
  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_RELU   = 2'd1;
  localparam logic [1:0] MODE_LEAKY  = 2'd2;
  localparam logic [1:0] MODE_LUT    = 2'd3;
  localparam logic signed [DATA_WIDTH:0] A_HALF = (DATA_WIDTH + 1)'(DEPTH / 2);
  localparam logic signed [DATA_WIDTH:0] A_TOP  = (DATA_WIDTH + 1)'(DEPTH - 1);
  localparam logic [LUT_ADDR_WIDTH-1:0]  ADDR_MAX = LUT_ADDR_WIDTH'(DEPTH - 1);
  localparam logic signed [PW-1:0] SAT_MAX =
    $signed({{(PW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}});
  localparam logic signed [PW-1:0] SAT_MIN =
    $signed({{(PW - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}});

  logic signed [DATA_WIDTH-1:0] lut_mem [DEPTH];

  logic stall, advance, accept, idle;
  logic                         s1_valid_q, s1_valid_d;
  logic [1:0]                   s1_mode_q, s1_mode_d;
  logic signed [DATA_WIDTH-1:0] s1_x_q, s1_x_d;
  logic                         s2_valid_q, s2_valid_d, s2_lut_q, s2_lut_d;
  logic signed [DATA_WIDTH-1:0] s2_simple_q, s2_simple_d;
  logic [FRAC_BITS-1:0]         s2_frac_q, s2_frac_d;
  logic [LUT_ADDR_WIDTH-1:0]    s2_addr_a_q, s2_addr_a_d, s2_addr_b_q, s2_addr_b_d;
  logic                         s3_valid_q, s3_valid_d, s3_lut_q, s3_lut_d;
  logic signed [DATA_WIDTH-1:0] s3_simple_q, s3_simple_d;
  logic [FRAC_BITS-1:0]         s3_frac_q, s3_frac_d;
  logic signed [DATA_WIDTH-1:0] lut_rd_a_q, lut_rd_b_q;
  logic                         out_valid_q, out_valid_d;
  logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic signed [DATA_WIDTH-1:0] x_shr;
  logic signed [DATA_WIDTH:0]   a_full, diff;
  logic signed [PW-1:0]         prod, sum, y_wide;

  always_comb begin
    stall   = out_valid_q && !bus.out_ready;
    advance = !stall;
    accept  = bus.in_valid && advance && !bus.lut_wr_en;
    idle    = !(s1_valid_q || s2_valid_q || s3_valid_q || out_valid_q);
  end

  assign bus.in_ready  = advance && !bus.lut_wr_en;
  assign bus.idle      = idle;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // Stage 1 capture and stage 2 index / fraction / simple-mode result
  always_comb begin
    s1_valid_d = accept;
    s1_mode_d  = bus.in_mode;
    s1_x_d     = $signed(bus.in_data);

    x_shr  = s1_x_q >>> FRAC_BITS;
    a_full = $signed({x_shr[DATA_WIDTH-1], x_shr}) + A_HALF;

    s2_valid_d  = s1_valid_q;
    s2_lut_d    = (s1_mode_q == MODE_LUT);
    s2_addr_a_d = a_full[LUT_ADDR_WIDTH-1:0];
    s2_addr_b_d = a_full[LUT_ADDR_WIDTH-1:0] + 1'b1;
    s2_frac_d   = s1_x_q[FRAC_BITS-1:0];
    // Clamped lookups use a zero fraction so the interpolator returns L[a] unchanged.
    if (a_full[DATA_WIDTH]) begin
      s2_addr_a_d = '0;
      s2_addr_b_d = '0;
      s2_frac_d   = '0;
    end else if (a_full >= A_TOP) begin
      s2_addr_a_d = ADDR_MAX;
      s2_addr_b_d = ADDR_MAX;
      s2_frac_d   = '0;
    end

    case (s1_mode_q)
      MODE_RELU:  s2_simple_d = s1_x_q[DATA_WIDTH-1] ? '0 : s1_x_q;
      MODE_LEAKY: s2_simple_d = s1_x_q[DATA_WIDTH-1] ? (s1_x_q >>> LEAK_SHIFT) : s1_x_q;
      MODE_BYPASS, MODE_LUT: s2_simple_d = s1_x_q;
      default:    s2_simple_d = s1_x_q;
    endcase
  end

  // Stage 3 carries control alongside the LUT read data; the output stage interpolates
  always_comb begin
    s3_valid_d  = s2_valid_q;
    s3_lut_d    = s2_lut_q;
    s3_simple_d = s2_simple_q;
    s3_frac_d   = s2_frac_q;

    diff   = $signed({lut_rd_b_q[DATA_WIDTH-1], lut_rd_b_q})
           - $signed({lut_rd_a_q[DATA_WIDTH-1], lut_rd_a_q});
    prod   = PW'(diff) * PW'($signed({1'b0, s3_frac_q}));
    sum    = PW'(lut_rd_a_q) + (prod >>> FRAC_BITS);
    y_wide = s3_lut_q ? sum : PW'(s3_simple_q);

    out_valid_d = s3_valid_q;
    if (y_wide > SAT_MAX)      out_data_d = SAT_MAX[DATA_WIDTH-1:0];
    else if (y_wide < SAT_MIN) out_data_d = SAT_MIN[DATA_WIDTH-1:0];
    else                       out_data_d = y_wide[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= '0;
      s1_x_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_lut_q    <= 1'b0;
      s2_simple_q <= '0;
      s2_frac_q   <= '0;
      s2_addr_a_q <= '0;
      s2_addr_b_q <= '0;
      s3_valid_q  <= 1'b0;
      s3_lut_q    <= 1'b0;
      s3_simple_q <= '0;
      s3_frac_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (advance) begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_x_q      <= s1_x_d;
      s2_valid_q  <= s2_valid_d;
      s2_lut_q    <= s2_lut_d;
      s2_simple_q <= s2_simple_d;
      s2_frac_q   <= s2_frac_d;
      s2_addr_a_q <= s2_addr_a_d;
      s2_addr_b_q <= s2_addr_b_d;
      s3_valid_q  <= s3_valid_d;
      s3_lut_q    <= s3_lut_d;
      s3_simple_q <= s3_simple_d;
      s3_frac_q   <= s3_frac_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // LUT contents survive reset; writes are only honoured with the pipe empty
  always_ff @(posedge clk) begin
    if (bus.lut_wr_en && idle) begin
      lut_mem[bus.lut_wr_addr] <= $signed(bus.lut_data);
    end
    if (advance) begin
      lut_rd_a_q <= lut_mem[s2_addr_a_q];
      lut_rd_b_q <= lut_mem[s2_addr_b_q];
    end
  end
endmodule

// File: tb/tb_activation_pipe_multi.sv
// Directed bench for activation_pipe_multi with an identity LUT, backpressure,
// LUT-write gating and mid-stream reset.
module tb_activation_pipe_multi;
  logic clk = 1'b0;
  logic rst;

  activation_pipe_multi_if #(.DATA_WIDTH(16), .LUT_ADDR_WIDTH(6)) bus ();

  activation_pipe_multi #(
    .DATA_WIDTH(16), .FRAC_BITS(8), .LUT_ADDR_WIDTH(6), .LEAK_SHIFT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h", tag, got, exp);
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic lut_write(input int addr, input logic [15:0] data);
    bus.lut_wr_en   = 1'b1;
    bus.lut_wr_addr = 6'(addr);
    bus.lut_data    = data;
    @(posedge clk); #1;
    bus.lut_wr_en   = 1'b0;
  endtask

  // One isolated sample: accepted at edge N, must appear after edge N+3, not N+2.
  task automatic run_single(input string tag, input logic [1:0] mode,
                            input logic [15:0] x, input logic [15:0] exp);
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_data  = x;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk({tag, "_early"}, bus.out_valid, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, bus.out_valid, 1'b1);
    chk({tag, "_data"}, bus.out_data, exp);
    $display("txn %-12s mode=%0d x=%h y=%h exp=%h", tag, mode, x, bus.out_data, exp);
    @(posedge clk); #1;
  endtask

  logic [1:0]  bp_mode [6] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd3, 2'd2};
  logic [15:0] bp_x    [6] = '{16'h0180, 16'hFF00, 16'hFF00, 16'h8001, 16'hFE80, 16'h0123};
  logic [15:0] bp_y    [6] = '{16'h0180, 16'h0000, 16'hFFE0, 16'h8001, 16'hFE80, 16'h0123};

  initial begin
    int idx, rx, seen;
    logic [15:0] held;
    logic stalled_prev;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_mode = 2'd0; bus.in_data = '0;
    bus.lut_wr_en = 1'b0; bus.lut_wr_addr = '0; bus.lut_data = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 16'h0000);
    chk("rst_idle", bus.idle, 1'b1);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int a = 0; a < 64; a++) lut_write(a, 16'((a - 32) * 256));

    run_single("lut_0180", 2'd3, 16'h0180, 16'h0180);
    run_single("lut_FE80", 2'd3, 16'hFE80, 16'hFE80);
    run_single("lut_7FFF", 2'd3, 16'h7FFF, 16'h1F00);
    run_single("lut_8000", 2'd3, 16'h8000, 16'hE000);
    run_single("lut_0040", 2'd3, 16'h0040, 16'h0040);
    run_single("relu_FF00", 2'd1, 16'hFF00, 16'h0000);
    run_single("relu_0123", 2'd1, 16'h0123, 16'h0123);
    run_single("leaky_FF00", 2'd2, 16'hFF00, 16'hFFE0);
    run_single("byp_8001", 2'd0, 16'h8001, 16'h8001);

    // Backpressure: six back-to-back samples, out_ready low for cycles 5..9
    idx = 0; rx = 0; held = '0; stalled_prev = 1'b0;
    for (int c = 0; c < 30; c++) begin
      bus.out_ready = !(c >= 5 && c < 10);
      bus.in_valid  = (idx < 6);
      if (idx < 6) begin
        bus.in_mode = bp_mode[idx];
        bus.in_data = bp_x[idx];
      end
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        chk("bp_in_ready", bus.in_ready, 1'b0);
        if (stalled_prev) chk("bp_hold", bus.out_data, held);
        held = bus.out_data;
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (rx < 6) begin
          chk("bp_data", bus.out_data, bp_y[rx]);
          $display("txn bp#%0d y=%h exp=%h", rx, bus.out_data, bp_y[rx]);
        end
        rx++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_sent", idx, 6);
    chk("bp_count", rx, 6);

    // LUT write while a sample is in flight must be dropped
    bus.in_valid = 1'b1; bus.in_mode = 2'd0; bus.in_data = 16'h0000;
    @(posedge clk); #1;
    bus.in_valid    = 1'b0;
    bus.lut_wr_en   = 1'b1;
    bus.lut_wr_addr = 6'd33;
    bus.lut_data    = 16'h0300;
    #1;
    chk("gate_idle", bus.idle, 1'b0);
    chk("gate_in_ready", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    bus.lut_wr_en = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("gate_drained", bus.idle, 1'b1);
    run_single("gate_old", 2'd3, 16'h0100, 16'h0100);
    lut_write(33, 16'h0300);
    run_single("gate_new", 2'd3, 16'h0100, 16'h0300);
    run_single("gate_interp", 2'd3, 16'h0080, 16'h0180);

    // Reset with two samples in flight and the head result stalled
    bus.in_valid = 1'b1; bus.in_mode = 2'd0; bus.in_data = 16'h1111;
    @(posedge clk); #1;
    bus.in_data = 16'h2222;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstm_pre_valid", bus.out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("rstm_out_valid", bus.out_valid, 1'b0);
    chk("rstm_out_data", bus.out_data, 16'h0000);
    chk("rstm_idle", bus.idle, 1'b1);
    chk("rstm_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("rstm_no_stale", seen, 0);
    // LUT keeps the rewritten entry across reset: 0x300 + ((0x200-0x300)*0x80 >>> 8)
    run_single("post_rst", 2'd3, 16'h0180, 16'h0280);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/activation_pipe_multi.md
ACTIVATION_PIPE_MULTI -- requirements
Module: activation_pipe_multi

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: signed fixed-point sample width.
REQ-002 SHALL have parameter FRAC_BITS, default 8: fractional bits of every sample and LUT entry.
REQ-003 SHALL have parameter LUT_ADDR_WIDTH, default 6: LUT depth = 2^LUT_ADDR_WIDTH entries.
REQ-004 SHALL have parameter LEAK_SHIFT, default 3: leaky-ReLU negative slope = 2^-LEAK_SHIFT.
REQ-005 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1: sample offered.
REQ-008 SHALL have port in_ready, output, 1: sample accepted when in_valid && in_ready.
REQ-009 SHALL have port in_mode, input, 2: 0 bypass, 1 ReLU, 2 leaky ReLU, 3 LUT with linear interpolation; sampled with each sample.
REQ-010 SHALL have port in_data, input, DATA_WIDTH: signed sample x.
REQ-011 SHALL have port lut_wr_en, input, 1: LUT write strobe.
REQ-012 SHALL have port lut_wr_addr, input, LUT_ADDR_WIDTH: LUT write address.
REQ-013 SHALL have port lut_data, input, DATA_WIDTH: signed LUT write data.
REQ-014 SHALL have port idle, output, 1: high when no sample is in any pipeline stage.
REQ-015 SHALL have port out_valid, output, 1: result available.
REQ-016 SHALL have port out_ready, input, 1: result consumed when out_valid && out_ready.
REQ-017 SHALL have port out_data, output, DATA_WIDTH: signed result y.

Function
REQ-018 SHALL be a 3-stage pipeline: S1 registers x and mode; S2 computes index, fraction, and ReLU/leaky/bypass result and reads two LUT entries; S3 interpolates, saturates, and drives out_data.
REQ-019 SHALL present a sample accepted at rising edge N on out_valid/out_data after edge N+3 when out_ready stays high.
REQ-020 SHALL sustain one sample per cycle with no bubbles while out_ready is high.
REQ-021 SHALL stall every stage in place while out_valid && !out_ready; in_ready = !(out_valid && !out_ready) && !lut_wr_en.
REQ-022 SHALL hold out_data stable while out_valid && !out_ready, and shall neither drop nor reorder samples.
REQ-023 SHALL output y = x in bypass mode.
REQ-024 SHALL output y = max(x, 0) in ReLU mode.
REQ-025 SHALL output y = x for x >= 0 and y = x >>> LEAK_SHIFT (arithmetic) for x < 0 in leaky mode.
REQ-026 SHALL, in LUT mode, compute i = x >>> FRAC_BITS and f = x[FRAC_BITS-1:0] (unsigned); LUT address a = i + 2^(LUT_ADDR_WIDTH-1), so entry a represents input value a - 2^(LUT_ADDR_WIDTH-1).
REQ-027 SHALL, for a in [0, 2^LUT_ADDR_WIDTH - 2], output y = L[a] + (((L[a+1] - L[a]) * f) >>> FRAC_BITS), using full-precision intermediates.
REQ-028 SHALL output L[2^LUT_ADDR_WIDTH - 1] when a >= 2^LUT_ADDR_WIDTH - 1 (upper clamp) and L[0] when a < 0 (lower clamp).
REQ-029 SHALL saturate y to the signed DATA_WIDTH range in all modes.
REQ-030 SHALL write lut_data to L[lut_wr_addr] at a rising edge with lut_wr_en high only when idle is high; lut_wr_en with idle low SHALL be ignored.
REQ-031 SHALL give priority to a LUT write over sample acceptance in the same cycle (in_ready low per REQ-021).
REQ-032 SHALL make a LUT write visible to any sample accepted on a later edge.

Reset
REQ-033 SHALL, while rst is high, immediately force out_valid=0, out_data=0, all stage valids=0, idle=1, and in_ready=1 (when lut_wr_en is low).
REQ-034 SHALL not reset LUT contents; samples in flight at reset are discarded and never appear after release.

Verification (DATA_WIDTH=16, FRAC_BITS=8, LUT_ADDR_WIDTH=6, LEAK_SHIFT=3; identity LUT L[a]=(a-32)*256)
REQ-035 SHALL be verified for LUT interpolation: 0x0180 -> 0x0180 exactly 3 cycles after acceptance; 0xFE80 -> 0xFE80; 0x7FFF -> 0x1F00; 0x8000 -> 0xE000.
REQ-036 SHALL be verified for ReLU and leaky modes: ReLU 0xFF00 -> 0x0000 and 0x0123 -> 0x0123; leaky 0xFF00 -> 0xFFE0; bypass 0x8001 -> 0x8001.
REQ-037 SHALL be verified for backpressure: 6 back-to-back samples with mixed modes and out_ready low for 5 cycles mid-stream -> in_ready low while stalled, out_data stable, all 6 results delivered in order.
REQ-038 SHALL be verified for a LUT-write gate: lut_wr_en with idle=0 -> entry unchanged; same write with idle=1 -> entry updated, and the next LUT-mode sample uses the new value.
REQ-039 SHALL be verified for reset mid-stream: rst asserted with 2 samples in flight -> out_valid drops immediately, idle=1, and no stale results appear after release.
